// File: rtl/dp_sram_pkg.sv
// dp_sram_pkg: shared constants and init state encoding for dp_sram_pipe
package dp_sram_pkg;
  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;
  localparam int MAX_READ_LATENCY = 2;
  typedef enum logic {ST_IDLE = 1'b0, ST_FILL = 1'b1} init_state_e;
endpackage

// File: rtl/dp_sram_init_fsm.sv
// dp_sram_init_fsm: post-reset zero-fill sequencer driving a write stream into the array
module dp_sram_init_fsm
  import dp_sram_pkg::*;
#(
  parameter int ADDR_WIDTH    = 4,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_busy,
  output logic                  zero_we,
  output logic [ADDR_WIDTH-1:0] zero_addr
);
  init_state_e state, state_next;
  logic [ADDR_WIDTH-1:0] cnt;
  logic last;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= (INIT_ON_RESET != 0) ? ST_FILL : ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (zero_we && !last) cnt <= cnt + 1'b1;
    end
  end
  always_comb begin
    last       = (cnt == '1);
    state_next = (state == ST_FILL && last) ? ST_IDLE : state;
  end
  assign init_busy = (state == ST_FILL);
  // reset itself never touches the array; only a fill cycle with rst low writes
  assign zero_we   = init_busy && !rst;
  assign zero_addr = cnt;
endmodule

// File: rtl/dp_sram_pipe.sv
// dp_sram_pipe: simple dual-port SRAM with byte enables, read-during-write select,
// 1/2-cycle registered read path and optional zero-fill after reset
module dp_sram_pipe
  import dp_sram_pkg::*;
#(
  parameter int ADDR_WIDTH    = 4,
  parameter int DATA_WIDTH    = 16,
  parameter int RDW_MODE      = 0,
  parameter int READ_LATENCY  = 1,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    csen_n,
  input  logic [ADDR_WIDTH-1:0]   addra,
  input  logic [DATA_WIDTH-1:0]   data_a,
  input  logic                    wrena_n,
  input  logic [DATA_WIDTH/8-1:0] bea,
  input  logic [ADDR_WIDTH-1:0]   addrb,
  input  logic                    rdenb_n,
  output logic [DATA_WIDTH-1:0]   data_b,
  output logic                    valid_b,
  output logic                    init_busy
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int DEPTH    = 2 ** ADDR_WIDTH;
  if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY || DATA_WIDTH % 8 != 0) begin : g_bad_cfg
    $error("dp_sram_pipe: READ_LATENCY must be 1 or 2 and DATA_WIDTH a multiple of 8");
  end
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  wr_acc, rd_acc, zero_we;
  logic [ADDR_WIDTH-1:0] zero_addr;
  logic [DATA_WIDTH-1:0] rd_word, rd_merged, rd_res, s1_data;
  logic                  s1_valid;
  dp_sram_init_fsm #(.ADDR_WIDTH(ADDR_WIDTH), .INIT_ON_RESET(INIT_ON_RESET)) u_init (
    .clk       (clk),
    .rst       (rst),
    .init_busy (init_busy),
    .zero_we   (zero_we),
    .zero_addr (zero_addr)
  );
  always_comb begin
    wr_acc    = !csen_n && !wrena_n && !init_busy;
    rd_acc    = !csen_n && !rdenb_n && !init_busy;
    rd_word   = mem[addrb];
    rd_merged = rd_word;
    for (int i = 0; i < BE_WIDTH; i++)
      if (bea[i]) rd_merged[8*i +: 8] = data_a[8*i +: 8];
    // new-data mode bypasses the pending write bytes over the pre-write word
    rd_res    = (RDW_MODE == RDW_NEW && wr_acc && addra == addrb) ? rd_merged : rd_word;
  end
  always_ff @(posedge clk) begin
    if (zero_we) mem[zero_addr] <= '0;
    else if (wr_acc)
      for (int i = 0; i < BE_WIDTH; i++)
        if (bea[i]) mem[addra][8*i +: 8] <= data_a[8*i +: 8];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_acc;
      if (rd_acc) s1_data <= rd_res;
    end
  end
  if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] s2_data;
    logic                  s2_valid;
    always_ff @(posedge clk) begin
      if (rst) begin
        s2_valid <= 1'b0;
        s2_data  <= '0;
      end else begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_data <= s1_data;
      end
    end
    assign data_b  = s2_data;
    assign valid_b = s2_valid;
  end else begin : g_lat1
    assign data_b  = s1_data;
    assign valid_b = s1_valid;
  end
endmodule

// File: tb/tb_dp_sram_pipe.sv
// tb_dp_sram_pipe: two configurations (old-data/lat1, new-data/lat2) driven in lockstep
module tb_dp_sram_pipe;
  logic clk = 1'b0, rst = 1'b1, csen_n = 1'b1, wrena_n = 1'b1, rdenb_n = 1'b1;
  logic [3:0] addra = '0, addrb = '0;
  logic [15:0] data_a = '0;
  logic [1:0] bea = '0;
  logic [15:0] d0, d1;
  logic v0, v1, b0, b1;
  always #5 clk = ~clk;
  dp_sram_pipe #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .RDW_MODE(0), .READ_LATENCY(1), .INIT_ON_RESET(1)) u0 (
    .clk(clk), .rst(rst), .csen_n(csen_n), .addra(addra), .data_a(data_a), .wrena_n(wrena_n),
    .bea(bea), .addrb(addrb), .rdenb_n(rdenb_n), .data_b(d0), .valid_b(v0), .init_busy(b0));
  dp_sram_pipe #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .RDW_MODE(1), .READ_LATENCY(2), .INIT_ON_RESET(1)) u1 (
    .clk(clk), .rst(rst), .csen_n(csen_n), .addra(addra), .data_a(data_a), .wrena_n(wrena_n),
    .bea(bea), .addrb(addrb), .rdenb_n(rdenb_n), .data_b(d1), .valid_b(v1), .init_busy(b1));
  typedef struct {int due; logic [15:0] d;} rd_t;
  rd_t q0[$], q1[$];
  logic [15:0] m_mem [16];
  int fill_left = 0, cyc = 0, errors = 0, checks = 0;
  logic ev0 = 1'b0, ev1 = 1'b0, eb = 1'b0;
  logic [15:0] ed0 = '0, ed1 = '0;
  // reference: apply this cycle's inputs, advance one edge, derive expected outputs
  task automatic tick();
    logic wa, ra;
    logic [15:0] old, nw;
    rd_t r;
    if (rst) begin
      q0.delete(); q1.delete();
      ed0 = '0; ed1 = '0;
      fill_left = 16;
    end else begin
      wa  = !csen_n && !wrena_n && fill_left == 0;
      ra  = !csen_n && !rdenb_n && fill_left == 0;
      old = m_mem[addrb];
      nw  = m_mem[addra];
      for (int i = 0; i < 2; i++) if (bea[i]) nw[8*i +: 8] = data_a[8*i +: 8];
      if (ra) begin
        q0.push_back('{cyc + 1, old});
        q1.push_back('{cyc + 2, (wa && addra == addrb) ? nw : old});
      end
      if (fill_left > 0) begin
        m_mem[16 - fill_left] = '0;
        fill_left--;
      end else if (wa) m_mem[addra] = nw;
    end
    @(posedge clk);
    cyc++;
    #1;
    eb  = fill_left > 0;
    ev0 = q0.size() > 0 && q0[0].due == cyc;
    if (ev0) begin r = q0.pop_front(); ed0 = r.d; end
    ev1 = q1.size() > 0 && q1[0].due == cyc;
    if (ev1) begin r = q1.pop_front(); ed1 = r.d; end
  endtask
  task automatic idle();
    csen_n = 1'b0; wrena_n = 1'b1; rdenb_n = 1'b1;
  endtask
  task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
    csen_n = 1'b0; wrena_n = 1'b0; rdenb_n = 1'b1; addra = a; data_a = d; bea = be;
    tick();
  endtask
  task automatic test_reset();
    int n;
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({v0, v1, d0, d1, b0, b1} !== {1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL reset_state got v=%b%b d0=%h d1=%h busy=%b%b exp v=00 d=0 busy=11", v0, v1, d0, d1, b0, b1);
    end
    rst = 1'b0;
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (!b0) break;
    end
    checks++;
    if (n != 16 || b1 !== 1'b0) begin
      errors++;
      $display("FAIL fill_length got %0d cycles busy1=%b exp 16 busy1=0", n, b1);
    end
    for (int i = 0; i < 18; i++) begin
      csen_n = 1'b0; wrena_n = 1'b1; rdenb_n = (i < 16) ? 1'b0 : 1'b1; addrb = 4'(i);
      tick();
      checks++;
      if ({v0, d0, v1, d1} !== {ev0, ed0, ev1, ed1} || (v0 && d0 !== 16'h0)) begin
        errors++;
        $display("FAIL fill_read i=%0d got v0=%b d0=%h v1=%b d1=%h exp v0=%b d0=%h v1=%b d1=%h",
                 i, v0, d0, v1, d1, ev0, ed0, ev1, ed1);
      end
    end
    idle();
  endtask
  task automatic test_byte_enables();
    wr(4'd5, 16'hABCD, 2'b11);
    wr(4'd5, 16'h12EF, 2'b10);
    wrena_n = 1'b1; rdenb_n = 1'b0; addrb = 4'd5;
    tick();
    idle();
    checks++;
    if (v0 !== 1'b1 || d0 !== 16'h12CD) begin
      errors++;
      $display("FAIL byte_en_lat1 got v=%b d=%h exp v=1 d=12cd", v0, d0);
    end
    tick();
    checks++;
    if (v1 !== 1'b1 || d1 !== 16'h12CD || v0 !== 1'b0) begin
      errors++;
      $display("FAIL byte_en_lat2 got v1=%b d1=%h v0=%b exp v1=1 d1=12cd v0=0", v1, d1, v0);
    end
  endtask
  task automatic test_collision();
    wr(4'd3, 16'h1111, 2'b11);
    csen_n = 1'b0; wrena_n = 1'b0; rdenb_n = 1'b0; addra = 4'd3; addrb = 4'd3; data_a = 16'h2222; bea = 2'b11;
    tick();
    idle();
    checks++;
    if (v0 !== 1'b1 || d0 !== 16'h1111) begin
      errors++;
      $display("FAIL rdw_old got v=%b d=%h exp v=1 d=1111", v0, d0);
    end
    tick();
    checks++;
    if (v1 !== 1'b1 || d1 !== 16'h2222) begin
      errors++;
      $display("FAIL rdw_new got v=%b d=%h exp v=1 d=2222", v1, d1);
    end
    rdenb_n = 1'b0; addrb = 4'd3;
    tick();
    idle();
    checks++;
    if (v0 !== 1'b1 || d0 !== 16'h2222) begin
      errors++;
      $display("FAIL rdw_after_old got v=%b d=%h exp v=1 d=2222", v0, d0);
    end
    tick();
    checks++;
    if (v1 !== 1'b1 || d1 !== 16'h2222) begin
      errors++;
      $display("FAIL rdw_after_new got v=%b d=%h exp v=1 d=2222", v1, d1);
    end
  endtask
  task automatic test_back_to_back();
    logic exp_v;
    for (int i = 0; i < 3; i++) wr(4'(i), 16'hA000 + 16'(i), 2'b11);
    idle();
    tick();
    for (int k = 0; k < 5; k++) begin
      rdenb_n = (k < 3) ? 1'b0 : 1'b1; addrb = 4'(k);
      tick();
      exp_v = (k >= 1 && k <= 3);
      checks++;
      if (v1 !== exp_v || (exp_v && d1 !== 16'hA000 + 16'(k - 1))) begin
        errors++;
        $display("FAIL lat2_stream k=%0d got v=%b d=%h exp v=%b d=%h", k, v1, d1, exp_v, 16'hA000 + 16'(k - 1));
      end
    end
    idle();
  endtask
  task automatic test_gating();
    wr(4'd7, 16'h5A5A, 2'b11);
    csen_n = 1'b1; wrena_n = 1'b0; rdenb_n = 1'b0; addra = 4'd7; addrb = 4'd7; data_a = 16'hFFFF; bea = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (v0 !== 1'b0 || v1 !== 1'b0) begin
        errors++;
        $display("FAIL csen_gate i=%0d got v0=%b v1=%b exp 0 0", i, v0, v1);
      end
    end
    csen_n = 1'b0; wrena_n = 1'b1;
    tick();
    idle();
    checks++;
    if (v0 !== 1'b1 || d0 !== 16'h5A5A) begin
      errors++;
      $display("FAIL csen_nowrite got v=%b d=%h exp v=1 d=5a5a", v0, d0);
    end
    tick();
  endtask
  task automatic test_reset_mid_fill();
    int n;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    csen_n = 1'b0; wrena_n = 1'b0; rdenb_n = 1'b0; addra = 4'd2; addrb = 4'd2; data_a = 16'hBEEF; bea = 2'b11;
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      checks++;
      if (v0 !== 1'b0 || v1 !== 1'b0) begin
        errors++;
        $display("FAIL busy_gate n=%0d got v0=%b v1=%b exp 0 0", n, v0, v1);
      end
      if (!b0) break;
    end
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL refill_length got %0d cycles exp 16", n);
    end
    wrena_n = 1'b1;
    tick();
    idle();
    checks++;
    if (v0 !== 1'b1 || d0 !== 16'h0) begin
      errors++;
      $display("FAIL first_access got v=%b d=%h exp v=1 d=0000", v0, d0);
    end
    tick();
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      csen_n  = ($urandom_range(0, 7) == 0);
      wrena_n = $urandom_range(0, 1);
      rdenb_n = ($urandom_range(0, 3) == 0);
      addra   = $urandom_range(0, 1) ? 4'($urandom_range(0, 3)) : 4'($urandom);
      addrb   = $urandom_range(0, 1) ? 4'($urandom_range(0, 3)) : 4'($urandom);
      data_a  = 16'($urandom);
      bea     = 2'($urandom);
      tick();
      checks++;
      if ({v0, d0, v1, d1, b0, b1} !== {ev0, ed0, ev1, ed1, eb, eb}) begin
        errors++;
        $display("FAIL random i=%0d got v0=%b d0=%h v1=%b d1=%h exp v0=%b d0=%h v1=%b d1=%h",
                 i, v0, d0, v1, d1, ev0, ed0, ev1, ed1);
      end
    end
    idle();
  endtask
  initial begin
    test_reset();
    test_byte_enables();
    test_collision();
    test_back_to_back();
    test_gating();
    test_reset_mid_fill();
    test_random();
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dp_sram_pipe.md
# dp_sram_pipe

Parametrised simple dual-port SRAM, the next generation of the team's basic dual-port memory. Port A writes, port B reads. It adds per-byte write enables and a selectable read-during-write result. It also adds a one- or two-cycle registered read path with a read-valid strobe, and an optional hardware zero-fill of the array after reset. It is intended as the common storage primitive under FIFOs, line buffers and register files.

## Interface
- ADDR_WIDTH, 4: address bits; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 16: word width; must be a multiple of 8. BE_WIDTH = DATA_WIDTH/8.
- RDW_MODE, 0: same-address read during write. 0 = old data; 1 = new data.
- READ_LATENCY, 1: 1 or 2 clocks from read request to data_b/valid_b. Other values are illegal; elaboration must fail.
- INIT_ON_RESET, 1: 1 = zero-fill the array after reset; 0 = contents undefined.
- clk  input  1  clock. All logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- csen_n  input  1  chip select, active low. Gates both ports.
- addra  input  ADDR_WIDTH  write address.
- data_a  input  DATA_WIDTH  write data.
- wrena_n  input  1  write enable, active low.
- bea  input  BE_WIDTH  byte enables, active high. Bit i covers data_a[8i+7:8i].
- addrb  input  ADDR_WIDTH  read address.
- rdenb_n  input  1  read enable, active low.
- data_b  output  DATA_WIDTH  read data, registered.
- valid_b  output  1  one-cycle strobe: data_b holds a new read result.
- init_busy  output  1  zero-fill in progress. Both ports are ignored while it is high.

## Operation
- Write accept: !csen_n && !wrena_n && !init_busy. Only the bytes with bea[i]=1 are updated. bea=0 is a legal no-op.
- Read accept: !csen_n && !rdenb_n && !init_busy. The read launches down the read pipeline.
- Collision: read and write accepted in the same cycle with addra==addrb.
  - RDW_MODE=0 returns the pre-write word.
  - RDW_MODE=1 returns the pre-write word with the enabled bytes replaced by data_a. This is a bypass mux, not a second array read.
- No accepted read: data_b holds its last value and valid_b=0.
- Init FSM states: IDLE and FILL.
  - rst forces FILL with the address counter at 0, when INIT_ON_RESET=1; otherwise rst forces IDLE.
  - FILL writes all-zero to counter address, one word per cycle.
  - Counter at 2**ADDR_WIDTH-1: that final word is written, then the FSM goes to IDLE.
  - The counter never wraps.
- init_busy = (state==FILL). It is 1 while rst is high, when INIT_ON_RESET=1.
- Reset during FILL restarts the fill from address 0.
- Reset never modifies array contents directly; only FILL does.
- Out-of-range addresses cannot occur, since depth is a full power of two.

## Timing
- Reset values: data_b=0, valid_b=0, all read pipeline stages invalid, init_busy=INIT_ON_RESET.
- READ_LATENCY=1: read accepted at edge N gives data_b/valid_b valid after edge N, i.e. during cycle N+1.
- READ_LATENCY=2: the same read is valid after edge N+1. The stage-2 register holds stage-1 data and valid.
- Back-to-back reads: one result per cycle, in order, no bubbles.
- A write at edge N is visible to a read accepted at edge N+1, independent of RDW_MODE.
- Fill duration: init_busy falls after exactly 2**ADDR_WIDTH edges with rst low. The first access can be accepted on the next edge.
- Reads issued during FILL produce no valid_b. Writes issued during FILL are dropped. The requester must watch init_busy.
- In-flight reads at assertion of rst are discarded; no valid_b follows.

## Structure
- Package dp_sram_pkg holds:
  - RDW_OLD=0 and RDW_NEW=1.
  - Init state encodings ST_IDLE and ST_FILL.
  - MAX_READ_LATENCY=2.
- Sub-module dp_sram_init_fsm: state register, address counter, init_busy, zero-write strobe and address. The top muxes its write request over port A.
- The top contains the array, the byte-merge write, the collision bypass and the latency pipeline.
- Target size is 150–250 lines in total.

## Test plan
- Reset fill, ADDR_WIDTH=4: rst high 3 cycles then low. Required:
  - init_busy high for exactly 16 cycles after rst falls.
  - A read of every address then returns 0x0000 with valid_b.
- Byte enables: write 0xABCD to address 5 with bea=11, then 0x12xx with bea=10. Read 5 -> 0x12CD.
- Collision: 0x1111 is at address 3; write 0x2222 to address 3 in the same cycle as a read of address 3. Required:
  - RDW_MODE=0 returns 0x1111.
  - RDW_MODE=1 returns 0x2222.
  - A following read returns 0x2222 in both modes.
- Latency: READ_LATENCY=2, reads of addresses 0,1,2 on consecutive edges. Required:
  - valid_b high for three consecutive cycles, starting two edges after the first read.
  - Data is in order.
- Gating: csen_n=1 with wrena_n=0 and rdenb_n=0. Required: no array change and valid_b=0. Repeat with init_busy=1; same result.
- Reset mid-fill: assert rst at counter=9, hold 1 cycle. Required: the fill restarts at 0 and init_busy stays high 16 more cycles.
